seg_anim_player: RTL and testbench
==================================

# seg_anim_player

Frame sequencer that sits directly upstream of the `seg7x16` display driver in image mode. It holds a writable table of 64-bit segment-code frames and steps through them at one of two selectable rates. It supports play/pause, direction, loop/one-shot and single-step. Its registered `o_data` drives `i_data` of `seg7x16`.

## Interface
Parameters:
- `FRAME_NUM`, 19: number of frames in the table; legal range 2..2^`ADDR_W`.
- `ADDR_W`, 5: frame index width.
- `DIV_SLOW`, 134217728: clocks per frame when `speed_sel`=1; must be ≥2.
- `DIV_FAST`, 33554432: clocks per frame when `speed_sel`=0; must be ≥2.

Ports (clock and reset first):
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `play`  in  1  level; 1 = run, 0 = stop.
- `step`  in  1  one-cycle pulse; advance one frame while stopped.
- `dir`  in  1  0 = ascending index, 1 = descending index.
- `loop`  in  1  1 = wrap at end of table, 0 = one-shot.
- `speed_sel`  in  1  selects `DIV_SLOW` (1) or `DIV_FAST` (0).
- `frame_wr_en`  in  1  table write strobe.
- `frame_wr_addr`  in  `ADDR_W`  table write address.
- `frame_wr_data`  in  64  segment codes for the frame; byte k drives digit k, active-low.
- `o_data`  out  64  current frame, registered.
- `o_frame_idx`  out  `ADDR_W`  current frame index.
- `o_tick`  out  1  one-cycle pulse on every frame advance.
- `o_done`  out  1  high while in S_END.

## Operation
Table:
- `FRAME_NUM` x 64-bit registers, initialised to all-ones (blank) at configuration.
- Reset does not clear the table.
- A write when `frame_wr_en`=1 and `frame_wr_addr` < `FRAME_NUM` takes effect at the clock edge.
- Writes with an out-of-range address are ignored.

State machine:
- S_STOP (reset state):
  - `play`=1 → S_RUN; prescaler starts at 0.
  - `step`=1 with `play`=0 → advance one frame with wrap, regardless of `loop`; pulse `o_tick`.
  - If `step` and `play` are both high, `play` wins and `step` is ignored.
- S_RUN:
  - Prescaler counts 0..DIV-1, where DIV is the divider selected by `speed_sel`.
  - At DIV-1 the prescaler returns to 0 and the frame advances.
  - `play`=0 → S_STOP; prescaler value is held so resume is seamless.
  - `step` is ignored.
- S_END: entered when a timed advance is attempted at the last frame with `loop`=0.
  - Index holds at the last frame; `o_done`=1; no `o_tick`.
  - `play`=0 → S_STOP, and the index is set to the start frame: 0 if `dir`=0, `FRAME_NUM`-1 if `dir`=1.

Advance rule:
- `dir`=0: idx+1; at `FRAME_NUM`-1, wraps to 0 when wrapping is allowed.
- `dir`=1: idx-1; at 0, wraps to `FRAME_NUM`-1 when wrapping is allowed.
- In S_RUN, wrapping is allowed only when `loop`=1. At the boundary with `loop`=0 the block goes to S_END and does not pulse `o_tick`.
- `dir` and `loop` are sampled at the advance edge; they may change at any time.

Speed change:
- Any change of `speed_sel` (detected against a registered copy) clears the prescaler to 0 on that cycle.
- No tick is generated on a speed-change cycle.

## Timing
- Reset values:
  - state S_STOP
  - `o_frame_idx`=0
  - prescaler=0
  - `o_data`=64'hFFFF_FFFF_FFFF_FFFF
  - `o_tick`=0
  - `o_done`=0
- `o_data` <= table[`o_frame_idx`] every cycle, so it lags an index change by 1 clock.
- A write to the currently displayed index appears on `o_data` 1 clock after the write edge.
- `o_tick` is registered and asserts in the same cycle that `o_frame_idx` shows the new value.
- S_STOP → S_RUN takes 1 clock after `play` rises. The first advance comes DIV clocks after entering S_RUN from a zero prescaler.
- A steady S_RUN advances exactly once every DIV clocks.
- A step pulse updates `o_frame_idx` at the next edge.
- `o_done` rises on the same edge that S_END is entered.
- Reset mid-run returns all outputs to their reset values immediately (asynchronously); table contents survive.

## Test plan
Bench configuration: `FRAME_NUM`=4, `DIV_FAST`=2, `DIV_SLOW`=4. Frame k is loaded with 64'h0101_0101_0101_0101 x k.

1. Load table; `play`=1, `dir`=0, `loop`=1, `speed_sel`=0 → `o_frame_idx` sequence 0,1,2,3,0,1, advancing every 2 clocks; one `o_tick` per advance; `o_data` matches each frame 1 clock later.
2. `loop`=0, `dir`=0, run from idx 0 → idx 3 is reached, then `o_done`=1 with no further `o_tick`. Drop `play` → S_STOP, idx=0, `o_done`=0.
3. Stopped at idx 0, `dir`=1, three `step` pulses → idx 3,2,1 with 3 `o_tick` pulses. `step` asserted together with `play` → run starts and no extra advance occurs.
4. Running at `speed_sel`=1; toggle `speed_sel` mid-count → prescaler restarts and the next advance comes exactly 2 clocks later. Drop `play` mid-count, then resume → the remaining count is preserved.
5. While idx=2 is displayed, write 64'hC0C0_C0C0_C0C0_C0C0 to addr 2 → `o_data` shows it 1 clock after the write. A write to addr 5 → no change to any frame.
6. Assert `rst` mid-run → `o_data` all-ones, idx 0, S_STOP. Table is preserved: `step` then shows frame 1's loaded value.

Source files
------------

// File: rtl/seg_anim_player_if.sv
// rtl/seg_anim_player_if.sv - control, frame-write and display bus of the frame sequencer
interface seg_anim_player_if #(
  parameter int ADDR_W = 5
);
  logic              play;
  logic              step;
  logic              dir;
  logic              loop;
  logic              speed_sel;
  logic              frame_wr_en;
  logic [ADDR_W-1:0] frame_wr_addr;
  logic [63:0]       frame_wr_data;
  logic [63:0]       o_data;
  logic [ADDR_W-1:0] o_frame_idx;
  logic              o_tick;
  logic              o_done;

  // Controller / table loader side
  modport master (
    output play, step, dir, loop, speed_sel,
    output frame_wr_en, frame_wr_addr, frame_wr_data,
    input  o_data, o_frame_idx, o_tick, o_done
  );

  // Sequencer side
  modport slave (
    input  play, step, dir, loop, speed_sel,
    input  frame_wr_en, frame_wr_addr, frame_wr_data,
    output o_data, o_frame_idx, o_tick, o_done
  );
endinterface

// File: rtl/seg_anim_player.sv
// rtl/seg_anim_player.sv - frame table sequencer feeding seg7x16 image mode
module seg_anim_player #(
  parameter int FRAME_NUM = 19,
  parameter int ADDR_W    = 5,
  parameter int DIV_SLOW  = 134217728,
  parameter int DIV_FAST  = 33554432
) (
  input  logic             clk,
  input  logic             rst,
  seg_anim_player_if.slave bus
);
  localparam int                DEPTH     = 1 << ADDR_W;
  localparam int                PW        = 32;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(FRAME_NUM - 1);
  localparam logic [ADDR_W:0]   FRAME_CNT = (ADDR_W + 1)'(FRAME_NUM);
  localparam logic [PW-1:0]     DIV_S_M1  = PW'(DIV_SLOW - 1);
  localparam logic [PW-1:0]     DIV_F_M1  = PW'(DIV_FAST - 1);

  typedef enum logic [1:0] {
    S_STOP = 2'd0,
    S_RUN  = 2'd1,
    S_END  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              tick_q, tick_d;
  logic              speed_q;
  logic [63:0]       data_q;

  // Table is sized to the full index space so any idx reads without width
  // games; entries at or above FRAME_NUM are never written and stay blank.
  logic [63:0]       frame_mem_q [DEPTH] = '{default: '1};

  logic [PW-1:0]     div_m1;
  logic              spd_chg;
  logic              at_last;
  logic [ADDR_W-1:0] idx_next;
  logic [ADDR_W-1:0] idx_start;

  // Advance arithmetic shared by step and timed advances
  always_comb begin
    div_m1    = bus.speed_sel ? DIV_S_M1 : DIV_F_M1;
    spd_chg   = bus.speed_sel != speed_q;
    at_last   = bus.dir ? (idx_q == '0) : (idx_q == LAST_IDX);
    idx_start = bus.dir ? LAST_IDX : '0;
    if (bus.dir) begin
      idx_next = (idx_q == '0) ? LAST_IDX : idx_q - 1'b1;
    end else begin
      idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // Next-state logic: play/pause, step, timed advance and one-shot end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    case (state_q)
      S_STOP: begin
        if (bus.play) begin
          state_d = S_RUN;
        end else if (bus.step) begin
          idx_d  = idx_next;
          tick_d = 1'b1;
        end
        if (spd_chg) presc_d = '0;
      end
      S_RUN: begin
        if (!bus.play) begin
          state_d = S_STOP;
          if (spd_chg) presc_d = '0;
        end else if (spd_chg) begin
          presc_d = '0;
        end else if (presc_q >= div_m1) begin
          presc_d = '0;
          if (at_last && !bus.loop) begin
            state_d = S_END;
          end else begin
            idx_d  = idx_next;
            tick_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      S_END: begin
        if (spd_chg) presc_d = '0;
        if (!bus.play) begin
          state_d = S_STOP;
          idx_d   = idx_start;
        end
      end
      default: begin
        state_d = S_STOP;
      end
    endcase
  end

  // Sequencer state, prescaler and display register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_STOP;
      idx_q   <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      speed_q <= 1'b0;
      data_q  <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      speed_q <= bus.speed_sel;
      data_q  <= frame_mem_q[idx_q];
    end
  end

  // Frame table writes; reset deliberately leaves contents intact
  always_ff @(posedge clk) begin
    if (bus.frame_wr_en && ({1'b0, bus.frame_wr_addr} < FRAME_CNT)) begin
      frame_mem_q[bus.frame_wr_addr] <= bus.frame_wr_data;
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_frame_idx = idx_q;
  assign bus.o_tick      = tick_q;
  assign bus.o_done      = (state_q == S_END);

endmodule

// File: tb/tb_seg_anim_player.sv
// tb/tb_seg_anim_player.sv - directed vector bench for seg_anim_player
module tb_seg_anim_player;
  localparam int FN = 4;
  localparam int AW = 3;
  localparam int DS = 4;
  localparam int DF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_anim_player_if #(.ADDR_W(AW)) bus ();

  seg_anim_player #(
    .FRAME_NUM(FN),
    .ADDR_W   (AW),
    .DIV_SLOW (DS),
    .DIV_FAST (DF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic          play;
    logic          step;
    logic          dir;
    logic          loop;
    logic [AW-1:0] idx;
    logic          tick;
    logic          done;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [63:0] C0_FRAME = 64'hC0C0_C0C0_C0C0_C0C0;

  function automatic logic [63:0] frame(input int k);
    return 64'h0101_0101_0101_0101 * k;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int p, input int s, input int d, input int l,
                     input int i, input int t, input int dn);
    vec_t v;
    v.play = p[0];
    v.step = s[0];
    v.dir  = d[0];
    v.loop = l[0];
    v.idx  = i[AW-1:0];
    v.tick = t[0];
    v.done = dn[0];
    vecs.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int prev;
    bus.play = 0; bus.step = 0; bus.dir = 0; bus.loop = 1; bus.speed_sel = 0;
    bus.frame_wr_en = 0; bus.frame_wr_addr = '0; bus.frame_wr_data = '0;

    // play step dir loop | idx tick done
    // loop run, fast rate: advance every 2 clocks, wrap 3->0
    add(1,0,0,1, 0,0,0); add(1,0,0,1, 0,0,0); add(1,0,0,1, 1,1,0);
    add(1,0,0,1, 1,0,0); add(1,0,0,1, 2,1,0); add(1,0,0,1, 2,0,0);
    add(1,0,0,1, 3,1,0); add(1,0,0,1, 3,0,0); add(1,0,0,1, 0,1,0);
    add(1,0,0,1, 0,0,0); add(1,0,0,1, 1,1,0);
    add(1,0,0,1, 1,0,0); add(1,0,0,1, 2,1,0); add(1,0,0,1, 2,0,0);
    add(1,0,0,1, 3,1,0); add(1,0,0,1, 3,0,0); add(1,0,0,1, 0,1,0);
    // one-shot from 0: reaches 3, then S_END with no tick
    add(1,0,0,0, 0,0,0); add(1,0,0,0, 1,1,0); add(1,0,0,0, 1,0,0);
    add(1,0,0,0, 2,1,0); add(1,0,0,0, 2,0,0); add(1,0,0,0, 3,1,0);
    add(1,0,0,0, 3,0,0); add(1,0,0,0, 3,0,1); add(1,0,0,0, 3,0,1);
    add(1,0,0,0, 3,0,1);
    // drop play: back to start frame 0
    add(0,0,0,0, 0,0,0); add(0,0,0,0, 0,0,0);
    // descending steps with wrap regardless of loop
    add(0,1,1,0, 3,1,0); add(0,0,1,0, 3,0,0); add(0,1,1,0, 2,1,0);
    add(0,0,1,0, 2,0,0); add(0,1,1,0, 1,1,0); add(0,0,1,0, 1,0,0);
    // step together with play: play wins, no extra advance
    add(1,1,1,0, 1,0,0); add(1,0,1,0, 1,0,0); add(1,0,1,0, 0,1,0);
    add(0,0,1,0, 0,0,0);

    // reset values while rst held
    cyc(); cyc();
    chk("rst_idx",  bus.o_frame_idx, 0);
    chk("rst_data", bus.o_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_tick", bus.o_tick, 0);
    chk("rst_done", bus.o_done, 0);
    rst = 0;

    // load table
    for (int k = 0; k < FN; k++) begin
      bus.frame_wr_en = 1; bus.frame_wr_addr = AW'(k); bus.frame_wr_data = frame(k);
      cyc();
    end
    bus.frame_wr_en = 0;
    cyc();
    chk("load_data0", bus.o_data, frame(0));

    // table-driven run/end/step sequence
    prev = 0;
    for (int n = 0; n < vecs.size(); n++) begin
      bus.play = vecs[n].play; bus.step = vecs[n].step;
      bus.dir  = vecs[n].dir;  bus.loop = vecs[n].loop;
      cyc();
      chk($sformatf("v%0d_idx", n),  bus.o_frame_idx, vecs[n].idx);
      chk($sformatf("v%0d_tick", n), bus.o_tick, vecs[n].tick);
      chk($sformatf("v%0d_done", n), bus.o_done, vecs[n].done);
      chk($sformatf("v%0d_data", n), bus.o_data, frame(prev));
      prev = int'(vecs[n].idx);
    end

    // speed change mid-count restarts the prescaler
    bus.step = 0; bus.dir = 0; bus.loop = 1; bus.play = 0; bus.speed_sel = 1;
    cyc();
    bus.play = 1;
    cyc(); cyc(); cyc();
    chk("spd_pre_idx", bus.o_frame_idx, 0);
    bus.speed_sel = 0;
    cyc();
    chk("spd_chg_idx",  bus.o_frame_idx, 0);
    chk("spd_chg_tick", bus.o_tick, 0);
    cyc();
    chk("spd_p1_idx", bus.o_frame_idx, 0);
    cyc();
    chk("spd_p2_idx",  bus.o_frame_idx, 1);
    chk("spd_p2_tick", bus.o_tick, 1);

    // pause mid-count keeps the remaining count
    bus.speed_sel = 1;
    cyc(); cyc(); cyc();
    bus.play = 0;
    cyc(); cyc(); cyc();
    chk("pause_idx", bus.o_frame_idx, 1);
    bus.play = 1;
    cyc();
    chk("resume1_idx", bus.o_frame_idx, 1);
    cyc();
    chk("resume2_idx", bus.o_frame_idx, 1);
    cyc();
    chk("resume3_idx",  bus.o_frame_idx, 2);
    chk("resume3_tick", bus.o_tick, 1);

    // write to displayed frame, then ignored out-of-range write
    bus.play = 0;
    cyc();
    chk("wr_stop_idx", bus.o_frame_idx, 2);
    cyc();
    chk("wr_old_data", bus.o_data, frame(2));
    bus.frame_wr_en = 1; bus.frame_wr_addr = 3'd2; bus.frame_wr_data = C0_FRAME;
    cyc();
    bus.frame_wr_en = 0;
    chk("wr_lag_data", bus.o_data, frame(2));
    cyc();
    chk("wr_new_data", bus.o_data, C0_FRAME);
    bus.frame_wr_en = 1; bus.frame_wr_addr = 3'd5; bus.frame_wr_data = 64'h1234_5678_9ABC_DEF0;
    cyc();
    bus.frame_wr_en = 0;
    cyc();
    chk("oor_data2", bus.o_data, C0_FRAME);
    bus.step = 1;
    cyc();
    bus.step = 0;
    chk("oor_step_idx", bus.o_frame_idx, 3);
    cyc();
    chk("oor_data3", bus.o_data, frame(3));
    bus.step = 1;
    cyc();
    bus.step = 0;
    chk("oor_wrap_idx", bus.o_frame_idx, 0);
    cyc();
    chk("oor_data0", bus.o_data, frame(0));

    // asynchronous reset mid-run, table survives
    bus.play = 1;
    cyc(); cyc(); cyc(); cyc(); cyc(); cyc();
    chk("prerst_idx", bus.o_frame_idx, 1);
    #3 rst = 1;
    #1;
    chk("arst_idx",  bus.o_frame_idx, 0);
    chk("arst_data", bus.o_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("arst_tick", bus.o_tick, 0);
    chk("arst_done", bus.o_done, 0);
    @(posedge clk);
    #1;
    rst = 0; bus.play = 0;
    cyc();
    chk("post_rst_idx", bus.o_frame_idx, 0);
    bus.step = 1;
    cyc();
    bus.step = 0;
    chk("post_step_idx",  bus.o_frame_idx, 1);
    chk("post_step_tick", bus.o_tick, 1);
    cyc();
    chk("post_step_data", bus.o_data, frame(1));
    chk("post_step_tick0", bus.o_tick, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
